// File: rtl/encoder4to2_arb_if.sv
// Handshake/select bundle between a requester group and encoder4to2_arb.
// The master side drives requests, enable and ready_in.
// The slave side (the arbiter) drives the registered code, grant, valid and busy.
interface encoder4to2_arb_if #(
  parameter int N  = 4,
  parameter int CW = 2
);
  logic [N-1:0]  req;
  logic          enable;
  logic          ready_in;
  logic [CW-1:0] code_out;
  logic          valid_out;
  logic [N-1:0]  grant;
  logic          busy;

  modport master (
    output req, enable, ready_in,
    input  code_out, valid_out, grant, busy
  );

  modport slave (
    input  req, enable, ready_in,
    output code_out, valid_out, grant, busy
  );
endinterface

// File: rtl/encoder4to2_arb.sv
// encoder4to2_arb: registered round-robin arbiter-encoder.
//
// Grants one of N level-sensitive requests. The winner is presented as a
// binary code plus a one-hot grant. Both are held under a valid/ready handshake.
// A granted code stays put until accepted. On acceptance the block can
// re-arbitrate on the same edge, giving one transfer per cycle when streaming.
//
// Reset is asynchronous and active-low.
//
// Build option ENC_FIXED_PRIORITY_EN: drops the rotating pointer. The search
// then always starts at index 0, so the block becomes a registered priority
// encoder with the same handshake.
module encoder4to2_arb #(
  parameter int N  = 4,
  parameter int CW = 2
) (
  input  logic             clk,
  input  logic             reset,
  encoder4to2_arb_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t        state_q, state_n;
  logic [CW-1:0] code_q,  code_n;
  logic [N-1:0]  grant_q, grant_n;
  logic          valid_q, valid_n;

  logic          handshake;
  logic [CW-1:0] search_start;
  logic [CW:0]   pick;

  // First set request at or after 'start', wrapping modulo N.
  // The result is {found, index}.
  function automatic logic [CW:0] rr_pick(input logic [N-1:0]  r,
                                          input logic [CW-1:0] start);
    logic          found;
    logic [CW-1:0] k;
    logic [CW-1:0] idx;
    found = 1'b0;
    k     = '0;
    for (int i = 0; i < N; i++) begin
      idx = start + CW'(i);
      if (!found && r[idx]) begin
        found = 1'b1;
        k     = idx;
      end
    end
    return {found, k};
  endfunction

  function automatic logic [N-1:0] onehot(input logic [CW-1:0] k);
    logic [N-1:0] v;
    v    = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  assign handshake = (state_q == HOLD) && bus.ready_in;

`ifdef ENC_FIXED_PRIORITY_EN
  assign search_start = '0;
`else
  logic [CW-1:0] ptr_q;

  // Rotate priority past the index just accepted.
  // The search on the handshake edge uses the post-acceptance pointer directly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         ptr_q <= '0;
    else if (handshake) ptr_q <= code_q + CW'(1);
  end

  assign search_start = handshake ? (code_q + CW'(1)) : ptr_q;
`endif

  assign pick = rr_pick(bus.req, search_start);

  // State and registered outputs; reset drops any held grant at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      code_q  <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_n;
      code_q  <= code_n;
      grant_q <= grant_n;
      valid_q <= valid_n;
    end
  end

  // Next-state logic. HOLD ignores req/enable until the consumer accepts.
  always_comb begin
    state_n = state_q;
    code_n  = code_q;
    grant_n = grant_q;
    valid_n = valid_q;
    unique case (state_q)
      IDLE: begin
        if (bus.enable && pick[CW]) begin
          code_n  = pick[CW-1:0];
          grant_n = onehot(pick[CW-1:0]);
          valid_n = 1'b1;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (bus.ready_in) begin
          if (bus.enable && pick[CW]) begin
            code_n  = pick[CW-1:0];
            grant_n = onehot(pick[CW-1:0]);
            valid_n = 1'b1;
            state_n = HOLD;
          end else begin
            code_n  = '0;
            grant_n = '0;
            valid_n = 1'b0;
            state_n = IDLE;
          end
        end
      end
      default: begin
        code_n  = '0;
        grant_n = '0;
        valid_n = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  assign bus.code_out  = code_q;
  assign bus.grant     = grant_q;
  assign bus.valid_out = valid_q;
  assign bus.busy      = (state_q == HOLD);

endmodule
